// File: rtl/seven_seg_reader.sv
// Seven-segment pattern reader: debounces strobed active-low segment samples and decodes stable patterns to hex.
// Optional error counter output enabled by defining SEG_READER_ERR_CNT_EN.
module seven_seg_reader #(
    parameter int unsigned STABLE_CNT = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] seg_n,
    input  logic       seg_strobe,
    input  logic       ready,
    output logic [3:0] digit,
    output logic       blank,
    output logic       invalid,
    output logic       valid
`ifdef SEG_READER_ERR_CNT_EN
    ,
    output logic [7:0] err_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

    localparam logic [3:0] STABLE = 4'(STABLE_CNT);
    localparam logic [6:0] BLANK_PAT = 7'h7F;

    state_t     state, state_next;
    logic [6:0] cand, cand_next;
    logic [3:0] count, count_next;
    logic [6:0] last_pat;
    logic       last_vld;
    logic       fresh, accept;
    logic [3:0] dec_digit;
    logic       dec_blank, dec_invalid;

    always_comb begin
        dec_digit   = 4'h0;
        dec_blank   = 1'b0;
        dec_invalid = 1'b0;
        case (seg_n)
            7'h40: dec_digit = 4'h0;
            7'h79: dec_digit = 4'h1;
            7'h24: dec_digit = 4'h2;
            7'h30: dec_digit = 4'h3;
            7'h19: dec_digit = 4'h4;
            7'h12: dec_digit = 4'h5;
            7'h02: dec_digit = 4'h6;
            7'h78: dec_digit = 4'h7;
            7'h00: dec_digit = 4'h8;
            7'h18: dec_digit = 4'h9;
            7'h08: dec_digit = 4'hA;
            7'h03: dec_digit = 4'hB;
            7'h46: dec_digit = 4'hC;
            7'h21: dec_digit = 4'hD;
            7'h06: dec_digit = 4'hE;
            7'h0E: dec_digit = 4'hF;
            BLANK_PAT: dec_blank = 1'b1;
            default: dec_invalid = 1'b1;
        endcase
    end

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_next = state;
        cand_next  = cand;
        count_next = count;
        fresh      = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (seg_strobe) begin
                    cand_next  = seg_n;
                    count_next = 4'd1;
                    fresh      = 1'b1;
                    state_next = SETTLE;
                end
            end
            SETTLE: begin
                if (seg_strobe) begin
                    if (seg_n == cand) begin
                        count_next = (count == 4'hF) ? 4'hF : count + 4'd1;
                    end else begin
                        cand_next  = seg_n;
                        count_next = 4'd1;
                        fresh      = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (ready) begin
                    state_next = IDLE;
                    count_next = 4'd0;
                end
            end
            default: state_next = IDLE;
        endcase
        // Accept only on the strobe that reaches the threshold, and never the same pattern twice in a row.
        if (state != HOLD && seg_strobe && count_next == STABLE && (fresh || count != STABLE)
            && (!last_vld || seg_n != last_pat)) begin
            accept     = 1'b1;
            state_next = HOLD;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cand     <= BLANK_PAT;
            count    <= 4'd0;
            last_pat <= BLANK_PAT;
            last_vld <= 1'b0;
            digit    <= 4'h0;
            blank    <= 1'b0;
            invalid  <= 1'b0;
            valid    <= 1'b0;
        end else begin
            state <= state_next;
            cand  <= cand_next;
            count <= count_next;
            valid <= (state_next == HOLD);
            if (accept) begin
                digit    <= dec_digit;
                blank    <= dec_blank;
                invalid  <= dec_invalid;
                last_pat <= seg_n;
                last_vld <= 1'b1;
            end
        end
    end

`ifdef SEG_READER_ERR_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_cnt <= 8'd0;
        end else if (accept && dec_invalid && err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_seven_seg_reader.sv
// Self-checking bench for seven_seg_reader: decode table vectors, directed corner sequences and
// randomized strobes compared against a run-length reference model.
module tb_seven_seg_reader;

    localparam int N = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] seg_n;
    logic       seg_strobe;
    logic       ready;
    logic [3:0] digit;
    logic       blank, invalid, valid;
`ifdef SEG_READER_ERR_CNT_EN
    logic [7:0] err_cnt;
`endif

    always #5 clk = ~clk;

    seven_seg_reader #(.STABLE_CNT(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .seg_n      (seg_n),
        .seg_strobe (seg_strobe),
        .ready      (ready),
        .digit      (digit),
        .blank      (blank),
        .invalid    (invalid),
        .valid      (valid)
`ifdef SEG_READER_ERR_CNT_EN
        ,
        .err_cnt    (err_cnt)
`endif
    );

    typedef struct {
        logic [6:0] seg;
        logic [3:0] digit;
        logic       blank;
        logic       invalid;
    } vec_t;

    int vectors = 0;
    int miscompares = 0;

    logic [6:0] pat_tab [16];

    // Reference model: length of the current run of identical strobed samples.
    bit         m_valid;
    logic [3:0] m_digit;
    bit         m_blank, m_invalid;
    logic [6:0] run_pat;
    int         run_len;
    logic [6:0] last_pat;
    bit         last_have;
    int         m_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid   = 0;
        m_digit   = 4'h0;
        m_blank   = 0;
        m_invalid = 0;
        run_len   = 0;
        run_pat   = 7'h7F;
        last_have = 0;
        m_err     = 0;
    endtask

    task automatic model_accept(input logic [6:0] p);
        m_valid   = 1;
        m_digit   = 4'h0;
        m_blank   = (p == 7'h7F);
        m_invalid = !m_blank;
        for (int i = 0; i < 16; i++) begin
            if (pat_tab[i] == p) begin
                m_digit   = 4'(i);
                m_invalid = 0;
            end
        end
        if (m_invalid && m_err < 255) m_err++;
        last_pat  = p;
        last_have = 1;
    endtask

    task automatic model_clock(input bit s, input logic [6:0] p, input bit r);
        if (m_valid) begin
            if (r) begin
                m_valid = 0;
                run_len = 0;
            end
        end else if (s) begin
            if (run_len > 0 && p == run_pat) begin
                run_len++;
            end else begin
                run_pat = p;
                run_len = 1;
            end
            if (run_len == N && !(last_have && p == last_pat)) model_accept(p);
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, compare on the falling edge.
    task automatic step(input bit s, input logic [6:0] p, input bit r);
        seg_strobe = s;
        seg_n      = p;
        ready      = r;
        @(posedge clk);
        model_clock(s, p, r);
        @(negedge clk);
        check("valid", valid, m_valid);
        if (m_valid) begin
            check("digit", digit, m_digit);
            check("blank", blank, m_blank);
            check("invalid", invalid, m_invalid);
        end
`ifdef SEG_READER_ERR_CNT_EN
        check("err_cnt", err_cnt, m_err);
`endif
    endtask

    task automatic strobe_n(input logic [6:0] p, input int n);
        for (int i = 0; i < n; i++) step(1, p, 0);
    endtask

    task automatic consume();
        step(0, 7'h00, 1);
        check("consume_valid", valid, 0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1;
        model_reset();
        @(negedge clk);
        reset = 0;
    endtask

    initial begin
        vec_t vecs [20];
        logic [6:0] rnd_set [6];
        logic [6:0] p;

        pat_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        vecs[0]  = '{7'h40, 4'h0, 0, 0};  vecs[1]  = '{7'h79, 4'h1, 0, 0};
        vecs[2]  = '{7'h24, 4'h2, 0, 0};  vecs[3]  = '{7'h30, 4'h3, 0, 0};
        vecs[4]  = '{7'h19, 4'h4, 0, 0};  vecs[5]  = '{7'h12, 4'h5, 0, 0};
        vecs[6]  = '{7'h02, 4'h6, 0, 0};  vecs[7]  = '{7'h78, 4'h7, 0, 0};
        vecs[8]  = '{7'h00, 4'h8, 0, 0};  vecs[9]  = '{7'h18, 4'h9, 0, 0};
        vecs[10] = '{7'h08, 4'hA, 0, 0};  vecs[11] = '{7'h03, 4'hB, 0, 0};
        vecs[12] = '{7'h46, 4'hC, 0, 0};  vecs[13] = '{7'h21, 4'hD, 0, 0};
        vecs[14] = '{7'h06, 4'hE, 0, 0};  vecs[15] = '{7'h0E, 4'hF, 0, 0};
        vecs[16] = '{7'h7F, 4'h0, 1, 0};  vecs[17] = '{7'h55, 4'h0, 0, 1};
        vecs[18] = '{7'h7E, 4'h0, 0, 1};  vecs[19] = '{7'h01, 4'h0, 0, 1};

        reset = 1; seg_n = 7'h00; seg_strobe = 0; ready = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_valid", valid, 0);
        check("rst_digit", digit, 0);
        check("rst_blank", blank, 0);
        check("rst_invalid", invalid, 0);
        reset = 0;

        // Decode table: each pattern strobed N times, checked, then consumed.
        for (int i = 0; i < 20; i++) begin
            strobe_n(vecs[i].seg, N - 1);
            check("tab_early_valid", valid, 0);
            step(1, vecs[i].seg, 0);
            check("tab_valid", valid, 1);
            check("tab_digit", digit, vecs[i].digit);
            check("tab_blank", blank, vecs[i].blank);
            check("tab_invalid", invalid, vecs[i].invalid);
            consume();
        end

        // Three strobes of 2, valid exactly one cycle after the third.
        strobe_n(7'h24, 2);
        check("lat_pre", valid, 0);
        step(1, 7'h24, 0);
        check("lat_valid", valid, 1);
        check("lat_digit", digit, 4'h2);
        consume();

        // A two-sample run of 1 is dropped in favour of 3.
        strobe_n(7'h79, 2);
        strobe_n(7'h30, 2);
        check("run_no1", valid, 0);
        step(1, 7'h30, 0);
        check("run_valid3", valid, 1);
        check("run_digit3", digit, 4'h3);
        consume();

        // Held result ignores strobes while ready is low.
        strobe_n(7'h46, 3);
        for (int i = 0; i < 10; i++) begin
            step(1, pat_tab[i], 0);
            check("hold_valid", valid, 1);
            check("hold_digit", digit, 4'hC);
        end
        // Consume with a strobe in the same cycle: that strobe does not count.
        step(1, 7'h40, 1);
        check("hold_release", valid, 0);
        strobe_n(7'h40, 2);
        check("same_cycle_ignored", valid, 0);
        step(1, 7'h40, 0);
        check("same_cycle_digit", digit, 4'h0);
        consume();

        // Blank then unmatched pattern, from a fresh reset so the error count starts at zero.
        pulse_reset();
        strobe_n(7'h7F, 3);
        check("blank_blank", blank, 1);
        check("blank_digit", digit, 0);
        consume();
        strobe_n(7'h55, 3);
        check("inv_invalid", invalid, 1);
        check("inv_blank", blank, 0);
`ifdef SEG_READER_ERR_CNT_EN
        check("inv_err_cnt", err_cnt, 1);
`endif
        consume();

        // Duplicate suppression.
        strobe_n(7'h40, 3);
        consume();
        for (int i = 0; i < 5; i++) begin
            step(1, 7'h40, 0);
            check("dup_suppress", valid, 0);
        end
        strobe_n(7'h00, 3);
        check("dup_new_valid", valid, 1);
        check("dup_new_digit", digit, 4'h8);
        consume();

        // Reset mid-settle discards the partial run.
        strobe_n(7'h12, 2);
        reset = 1;
        #1;
        check("mid_rst_valid", valid, 0);
        check("mid_rst_digit", digit, 0);
        check("mid_rst_blank", blank, 0);
        check("mid_rst_invalid", invalid, 0);
        model_reset();
        @(negedge clk);
        reset = 0;
        step(1, 7'h12, 0);
        check("post_rst_nov", valid, 0);
        strobe_n(7'h12, 2);
        check("post_rst_digit", digit, 4'h5);
        // Reset mid-hold drops the pending result.
        reset = 1;
        #1;
        check("hold_rst_valid", valid, 0);
        model_reset();
        @(negedge clk);
        reset = 0;

        // Randomized strobes over a small pattern set so stable runs occur often.
        rnd_set = '{7'h40, 7'h79, 7'h24, 7'h7F, 7'h55, 7'h12};
        p = rnd_set[0];
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) < 4) p = rnd_set[$urandom_range(0, 5)];
            step($urandom_range(0, 3) != 0, p, $urandom_range(0, 2) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seven_seg_reader.md
SEVEN_SEG_READER -- requirements
Module: seven_seg_reader

Interface
REQ-001 Parameter STABLE_CNT, default 3, number of consecutive identical strobed samples required to accept a pattern (range 1..15).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 seg_n  input  7  active-low segment lines; bit0=a, bit1=b, bit2=c, bit3=d, bit4=e, bit5=f, bit6=g.
REQ-005 seg_strobe  input  1  sample qualifier; seg_n is sampled only in cycles where seg_strobe=1.
REQ-006 digit  output  4  recovered hex value of accepted pattern.
REQ-007 blank  output  1  accepted pattern was all segments off (7'h7F).
REQ-008 invalid  output  1  accepted pattern matched no table entry and was not blank.
REQ-009 valid  output  1  digit/blank/invalid hold a new accepted result.
REQ-010 ready  input  1  consumer accepts result when valid=1 and ready=1 in same cycle.

Function
REQ-011 Decode table, seg_n to digit: 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 18->9, 08->A, 03->b, 46->C, 21->d, 06->E, 0E->F (hex).
REQ-012 Blank (7F): digit=0, blank=1, invalid=0; unmatched pattern: digit=0, blank=0, invalid=1.
REQ-013 States: IDLE, SETTLE, HOLD.
REQ-014 IDLE: on strobe, register sample as candidate, stable count=1, go SETTLE (or, if STABLE_CNT=1, accept immediately per REQ-016).
REQ-015 SETTLE: on strobe with sample equal to candidate, increment count; on strobe with different sample, replace candidate, count=1; no strobe, hold.
REQ-016 Acceptance: in the cycle count reaches STABLE_CNT, outputs load decoded result, valid=1 next cycle, state HOLD.
REQ-017 Latency: valid rises exactly one cycle after the STABLE_CNT-th matching strobe.
REQ-018 Duplicate suppression: a stable pattern equal to the last accepted pattern is not re-accepted; a new result requires a different stable pattern.
REQ-019 HOLD: valid, digit, blank, invalid held constant until valid&ready; strobes while valid=1 ignored.
REQ-020 On valid&ready: valid=0 next cycle, state IDLE, last-accepted pattern retained.
REQ-021 Result consumed and new strobe in same cycle: strobe ignored; sampling resumes next cycle.
REQ-022 Count is 4-bit and saturates; it never wraps.

Reset
REQ-023 On reset: state IDLE, valid=0, digit=0, blank=0, invalid=0, count=0, candidate=7'h7F, last-accepted pattern cleared to "none" (first stable pattern always accepted).
REQ-024 Reset asserted mid-SETTLE or mid-HOLD discards candidate and pending result immediately; no valid after reset release until REQ-016 satisfied anew.

Configuration
REQ-025 Macro SEG_READER_ERR_CNT_EN.
REQ-026 Defined: output err_cnt (8 bits) exists, increments by 1 on each accepted invalid result, saturates at 255, reset to 0.
REQ-027 Undefined: port err_cnt absent; all other behaviour identical.

Verification
REQ-028 STABLE_CNT=3; strobe 7'h24 three times consecutively -> valid=1 one cycle after third strobe, digit=2, blank=0, invalid=0.
REQ-029 Strobe 7'h79, 7'h79, 7'h30, 7'h30, 7'h30 -> single result digit=3; no result for 1.
REQ-030 Accepted result, ready=0 for 10 cycles with differing strobes -> outputs unchanged; ready=1 -> valid=0 next cycle.
REQ-031 Strobe 7'h7F x3 -> blank=1, digit=0; then 7'h55 x3 -> invalid=1 and, with SEG_READER_ERR_CNT_EN, err_cnt=1.
REQ-032 After accepting 7'h40 and consuming it, strobe 7'h40 x5 -> no new valid; then 7'h00 x3 -> digit=8.
REQ-033 Assert reset after two matching strobes of 7'h12 -> all outputs 0; after release, 7'h12 x3 -> digit=5.
